// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the RV64M multiply/divide unit: func3 encodings,
// FSM state type and default datapath width.
package ex_muldiv_unit_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } muldiv_state_e;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-side handshake of the multiply/divide unit; master is the pipeline,
// slave is the unit.
interface ex_muldiv_unit_if #(parameter int unsigned XLEN = 64);

    logic            flush_i;
    logic            valid_i;
    logic [3:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic [XLEN-1:0] result_o;
    logic            done_o;
    logic            stall_o;
    logic            busy_o;

    modport master (
        output flush_i, valid_i, op_i, a_i, b_i,
        input  result_o, done_o, stall_o, busy_o
    );

    modport slave (
        input  flush_i, valid_i, op_i, a_i, b_i,
        output result_o, done_o, stall_o, busy_o
    );

endinterface

// File: rtl/ex_muldiv_unit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_restoring_step #(parameter int unsigned XLEN = 64) (
    input  logic [XLEN-1:0] rem,
    input  logic            dvd_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        shifted  = {rem, dvd_bit};
        diff     = shifted - {1'b0, divisor};
        // top bit of the widened difference is the borrow
        q_bit    = ~diff[XLEN];
        rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M multiply/divide engine in EX. Define MULDIV_FAST_MUL_EN to
// replace the shift-add multiplier with a single-cycle `*`.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    ex_muldiv_unit_if.slave   mdu
);

    localparam int unsigned HW = XLEN / 2;
    localparam int unsigned CW = $clog2(XLEN + 1);

    muldiv_state_e     state_q, state_d;
    logic [CW-1:0]     count_q;
    logic              word_q, neg_q, rneg_q;
    logic [2:0]        f3_q;
    logic [2*XLEN-1:0] acc_q, opb_q, acc_nx, prod;
    logic [XLEN-1:0]   mplier_q, result_q;

    logic              accept, word_in, zext_in, is_div_in, sa_use, sb_use, sa, sb;
    logic              div_zero, div_ovf, illegal_w, special_in, last_iter, q_bit;
    logic [2:0]        f3_in;
    logic [XLEN-1:0]   a_ext, b_ext, mag_a, mag_b, min_val, spec_res, dvd_init;
    logic [XLEN-1:0]   rem_nx, quo_s, rem_s, res_raw, calc_res;

    function automatic logic [XLEN-1:0] fix_word(input logic w, input logic [XLEN-1:0] v);
        return w ? {{HW{v[HW-1]}}, v[HW-1:0]} : v;
    endfunction

    assign accept = (state_q == ST_IDLE) && mdu.valid_i && !mdu.flush_i;

    // Operand conditioning and special-case detection at accept
    always_comb begin
        word_in   = mdu.op_i[3];
        f3_in     = mdu.op_i[2:0];
        is_div_in = f3_in[2];
        // MULW uses the low halves unsigned: the low half of a product is sign-agnostic
        zext_in   = word_in && !(f3_in == F3_DIV || f3_in == F3_REM);
        a_ext     = mdu.a_i;
        b_ext     = mdu.b_i;
        if (word_in) begin
            a_ext = {{HW{zext_in ? 1'b0 : mdu.a_i[HW-1]}}, mdu.a_i[HW-1:0]};
            b_ext = {{HW{zext_in ? 1'b0 : mdu.b_i[HW-1]}}, mdu.b_i[HW-1:0]};
        end
        sa_use   = is_div_in ? !f3_in[0] : (f3_in == F3_MULH || f3_in == F3_MULHSU);
        sb_use   = is_div_in ? !f3_in[0] : (f3_in == F3_MULH);
        sa       = sa_use & a_ext[XLEN-1];
        sb       = sb_use & b_ext[XLEN-1];
        mag_a    = sa ? -a_ext : a_ext;
        mag_b    = sb ? -b_ext : b_ext;
        dvd_init = word_in ? (mag_a << HW) : mag_a;
        min_val  = word_in ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        illegal_w  = word_in && !is_div_in && (f3_in != F3_MUL);
        div_zero   = is_div_in && (b_ext == '0);
        div_ovf    = is_div_in && !f3_in[0] && (a_ext == min_val) && (b_ext == '1);
        special_in = illegal_w || div_zero || div_ovf;
        spec_res   = '0;
        if (div_zero)
            spec_res = f3_in[1] ? a_ext : '1;
        else if (div_ovf)
            spec_res = f3_in[1] ? '0 : a_ext;
    end

    div_restoring_step #(.XLEN(XLEN)) u_div_step (
        .rem      (acc_q[2*XLEN-1:XLEN]),
        .dvd_bit  (acc_q[XLEN-1]),
        .divisor  (opb_q[XLEN-1:0]),
        .rem_next (rem_nx),
        .q_bit    (q_bit)
    );

    // One CALC iteration plus sign fixup of the would-be final value
    always_comb begin
        if (f3_q[2])
            acc_nx = {rem_nx, acc_q[XLEN-2:0], q_bit};
        else begin
`ifdef MULDIV_FAST_MUL_EN
            acc_nx = {{XLEN{1'b0}}, opb_q[XLEN-1:0]} * {{XLEN{1'b0}}, mplier_q};
`else
            acc_nx = acc_q + (mplier_q[0] ? opb_q : '0);
`endif
        end
        prod  = neg_q ? -acc_nx : acc_nx;
        quo_s = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
        rem_s = rneg_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
        if (f3_q[2])
            res_raw = f3_q[1] ? rem_s : quo_s;
        else
            res_raw = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        calc_res = fix_word(word_q, res_raw);
`ifdef MULDIV_FAST_MUL_EN
        if (!f3_q[2])
            last_iter = 1'b1;
        else
`endif
        last_iter = (count_q == CW'(word_q ? HW - 1 : XLEN - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = special_in ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (mdu.flush_i)
                    state_d = ST_IDLE;
                else if (last_iter)
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            word_q   <= 1'b0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= '0;
            opb_q    <= '0;
            mplier_q <= '0;
            result_q <= '0;
        end else if (accept) begin
            count_q  <= '0;
            word_q   <= word_in;
            f3_q     <= f3_in;
            neg_q    <= sa ^ sb;
            rneg_q   <= sa;
            acc_q    <= is_div_in ? {{XLEN{1'b0}}, dvd_init} : '0;
            opb_q    <= {{XLEN{1'b0}}, is_div_in ? mag_b : mag_a};
            mplier_q <= mag_b;
            if (special_in)
                result_q <= fix_word(word_in, spec_res);
        end else if (state_q == ST_CALC && !mdu.flush_i) begin
            acc_q   <= acc_nx;
            count_q <= count_q + CW'(1);
            if (!f3_q[2]) begin
                opb_q    <= opb_q << 1;
                mplier_q <= mplier_q >> 1;
            end
            if (last_iter)
                result_q <= calc_res;
        end
    end

    always_comb begin
        mdu.busy_o   = (state_q != ST_IDLE);
        mdu.done_o   = (state_q == ST_DONE);
        mdu.stall_o  = !reset && (accept || state_q == ST_CALC);
        mdu.result_o = result_q;
    end

endmodule
